// File: rtl/cpu_bringup_ctrl.sv
// Bring-up sequencer around a CPU core: holds the core in reset for a programmable time,
// runs it under a cycle budget, and reports pass/fail/timeout from a TOHOST store.
module cpu_bringup_ctrl #(
  parameter int unsigned       RST_HOLD_CYCLES = 2,
  parameter int unsigned       MAX_CYCLES      = 50,
  parameter int unsigned       CNT_W           = 32,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR     = ADDR_W'(32'h0000_0FFC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              retire_valid_i,
  input  logic              dmem_we_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  retire_count_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int unsigned RUN_W  = $clog2(MAX_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(MAX_CYCLES - 1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  // Unsaturated budget counter: the visible cycle_count may saturate before the budget expires
  logic [RUN_W-1:0]    run_q, run_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   fail_code_q, fail_code_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    retire_q, retire_d;

  logic tohost_hit;
  logic budget_hit;
  logic restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign tohost_hit = dmem_we_i && (dmem_addr_i == TOHOST_ADDR);
  assign budget_hit = (run_q == RUN_LAST);
  assign restart    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_HOLD;
      S_HOLD: if (hold_q == HOLD_LAST) state_d = S_RUN;
      S_RUN:  if (tohost_hit || budget_hit) state_d = S_DONE;
      S_DONE: if (start_i) state_d = S_HOLD;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    run_d       = run_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    retire_d    = retire_q;

    if (restart) begin
      hold_d      = '0;
      run_d       = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_code_d = '0;
      cycle_d     = '0;
      retire_d    = '0;
    end else if (state_q == S_HOLD) begin
      hold_d = hold_q + HOLD_W'(1);
    end else if (state_q == S_RUN) begin
      run_d   = run_q + RUN_W'(1);
      cycle_d = sat_inc(cycle_q);
      if (retire_valid_i) retire_d = sat_inc(retire_q);
      // A TOHOST store in the budget's last cycle still counts as a real result
      if (tohost_hit) begin
        done_d      = 1'b1;
        fail_code_d = dmem_wdata_i;
        pass_d      = (dmem_wdata_i == DATA_W'(1));
        fail_d      = (dmem_wdata_i != DATA_W'(1));
      end else if (budget_hit) begin
        done_d      = 1'b1;
        timeout_d   = 1'b1;
        fail_d      = 1'b1;
        fail_code_d = '0;
      end
    end

    cpu_rst_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d    = (state_d == S_HOLD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      run_q       <= '0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      cycle_q     <= '0;
      retire_q    <= '0;
    end else begin
      hold_q      <= hold_d;
      run_q       <= run_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      retire_q    <= retire_d;
    end
  end

  assign cpu_rst_o      = cpu_rst_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign fail_code_o    = fail_code_q;
  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;

endmodule

// File: tb/tb_cpu_bringup_ctrl.sv
// Bench for cpu_bringup_ctrl: a default instance and a narrow-counter instance, both
// checked every cycle against an elapsed-time model, plus directed literal checks.
module tb_cpu_bringup_ctrl;

  localparam int HOLD = 2;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        st [2];
  logic        rv [2];
  logic        we [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];

  logic        o_rst  [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_pass [2];
  logic        o_fail [2];
  logic        o_to   [2];
  logic [31:0] o_code [2];
  logic [31:0] o_cyc0, o_ret0;
  logic [3:0]  o_cyc1, o_ret1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_bringup_ctrl #(
    .RST_HOLD_CYCLES(2), .MAX_CYCLES(50), .CNT_W(32),
    .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(32'h0000_0FFC)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st[0]), .retire_valid_i(rv[0]),
    .dmem_we_i(we[0]), .dmem_addr_i(ad[0]), .dmem_wdata_i(wd[0]),
    .cpu_rst_o(o_rst[0]), .busy_o(o_busy[0]), .done_o(o_done[0]),
    .pass_o(o_pass[0]), .fail_o(o_fail[0]), .timeout_o(o_to[0]),
    .fail_code_o(o_code[0]), .cycle_count_o(o_cyc0), .retire_count_o(o_ret0)
  );

  cpu_bringup_ctrl #(
    .RST_HOLD_CYCLES(2), .MAX_CYCLES(40), .CNT_W(4),
    .ADDR_W(32), .DATA_W(32), .TOHOST_ADDR(32'h0000_0FFC)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st[1]), .retire_valid_i(rv[1]),
    .dmem_we_i(we[1]), .dmem_addr_i(ad[1]), .dmem_wdata_i(wd[1]),
    .cpu_rst_o(o_rst[1]), .busy_o(o_busy[1]), .done_o(o_done[1]),
    .pass_o(o_pass[1]), .fail_o(o_fail[1]), .timeout_o(o_to[1]),
    .fail_code_o(o_code[1]), .cycle_count_o(o_cyc1), .retire_count_o(o_ret1)
  );

  // Model: a run is described by edges elapsed since the start edge; edges beyond HOLD are RUN cycles.
  bit          m_active [2];
  bit          m_done   [2];
  bit          m_pass   [2];
  bit          m_fail   [2];
  bit          m_to     [2];
  int          m_el     [2];
  logic [31:0] m_code   [2];
  longint      m_runs   [2];
  longint      m_ret    [2];

  function automatic int maxc(int i);
    return (i == 0) ? 50 : 40;
  endfunction

  function automatic longint lim(int i);
    return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
  endfunction

  function automatic longint sat(int i, longint v);
    return (v > lim(i)) ? lim(i) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_to[i] = 0;
      m_el[i] = 0; m_code[i] = '0; m_runs[i] = 0; m_ret[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    if (st[i] && !m_active[i]) begin
      m_active[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_to[i] = 0;
      m_el[i] = 0; m_code[i] = '0; m_runs[i] = 0; m_ret[i] = 0;
    end else if (m_active[i]) begin
      m_el[i]++;
      if (m_el[i] > HOLD) begin
        m_runs[i]++;
        if (rv[i]) m_ret[i]++;
        if (we[i] && ad[i] == TOHOST) begin
          m_active[i] = 0; m_done[i] = 1; m_code[i] = wd[i];
          m_pass[i] = (wd[i] == 32'd1); m_fail[i] = (wd[i] != 32'd1);
        end else if (m_runs[i] == longint'(maxc(i))) begin
          m_active[i] = 0; m_done[i] = 1; m_to[i] = 1; m_fail[i] = 1; m_code[i] = '0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_inst(int i, logic [31:0] cyc, logic [31:0] ret);
    string p;
    p = $sformatf("i%0d.", i);
    chk({p, "cpu_rst"}, 64'(o_rst[i]), 64'(m_active[i] ? (m_el[i] < HOLD) : !m_done[i]));
    chk({p, "busy"}, 64'(o_busy[i]), 64'(m_active[i]));
    chk({p, "done"}, 64'(o_done[i]), 64'(m_done[i]));
    chk({p, "pass"}, 64'(o_pass[i]), 64'(m_pass[i]));
    chk({p, "fail"}, 64'(o_fail[i]), 64'(m_fail[i]));
    chk({p, "timeout"}, 64'(o_to[i]), 64'(m_to[i]));
    chk({p, "fail_code"}, 64'(o_code[i]), 64'(m_code[i]));
    chk({p, "cycle_count"}, 64'(cyc), sat(i, m_runs[i]));
    chk({p, "retire_count"}, 64'(ret), sat(i, m_ret[i]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, o_cyc0, o_ret0);
      cmp_inst(1, {28'd0, o_cyc1}, {28'd0, o_ret1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in(int i);
    st[i] = 0; rv[i] = 0; we[i] = 0; ad[i] = '0; wd[i] = '0;
  endtask

  // Leaves the bench 1ns after the edge that samples start.
  task automatic kick(int i);
    step();
    st[i] = 1;
    step();
    st[i] = 0;
  endtask

  task automatic wait_done(int i, int budget);
    int n = 0;
    while (o_done[i] !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("i%0d.wait_done", i), 64'(o_done[i]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) clr_in(i);
    #1 rst = 1;
    #22 rst = 0;
    #1;
    chk("reset.cpu_rst", 64'(o_rst[0]), 64'd1);
    chk("reset.busy", 64'(o_busy[0]), 64'd0);
    chk("reset.cycle_count", 64'(o_cyc0), 64'd0);

    // Test 1: pass on RUN cycle 10
    kick(0);
    chk("t1.cpu_rst_e0", 64'(o_rst[0]), 64'd1);
    chk("t1.busy_e0", 64'(o_busy[0]), 64'd1);
    step();
    chk("t1.cpu_rst_e1", 64'(o_rst[0]), 64'd1);
    step();
    chk("t1.cpu_rst_e2", 64'(o_rst[0]), 64'd0);
    repeat (10) step();
    we[0] = 1; ad[0] = TOHOST; wd[0] = 32'd1;
    step();
    clr_in(0);
    chk("t1.done", 64'(o_done[0]), 64'd1);
    chk("t1.pass", 64'(o_pass[0]), 64'd1);
    chk("t1.fail_code", 64'(o_code[0]), 64'd1);
    chk("t1.cycle_count", 64'(o_cyc0), 64'd11);
    // Activity in DONE must not disturb the frozen result
    we[0] = 1; ad[0] = TOHOST; wd[0] = 32'd5; rv[0] = 1;
    repeat (2) step();
    clr_in(0);
    chk("t1.frozen_code", 64'(o_code[0]), 64'd1);
    chk("t1.frozen_retire", 64'(o_ret0), 64'd0);
    chk("t1.frozen_cycles", 64'(o_cyc0), 64'd11);

    // Test 2: timeout after 50 RUN cycles, restarted from DONE
    kick(0);
    wait_done(0, 80);
    chk("t2.timeout", 64'(o_to[0]), 64'd1);
    chk("t2.fail", 64'(o_fail[0]), 64'd1);
    chk("t2.pass", 64'(o_pass[0]), 64'd0);
    chk("t2.cycle_count", 64'(o_cyc0), 64'd50);
    chk("t2.fail_code", 64'(o_code[0]), 64'd0);

    // Test 3: TOHOST store on the timeout cycle wins
    kick(0);
    repeat (2) step();
    repeat (49) step();
    we[0] = 1; ad[0] = TOHOST; wd[0] = 32'h2A;
    step();
    clr_in(0);
    chk("t3.done", 64'(o_done[0]), 64'd1);
    chk("t3.fail", 64'(o_fail[0]), 64'd1);
    chk("t3.timeout", 64'(o_to[0]), 64'd0);
    chk("t3.fail_code", 64'(o_code[0]), 64'h2A);
    chk("t3.cycle_count", 64'(o_cyc0), 64'd50);

    // Test 4: retire on odd cycles, stray writes to 0xFF8, start ignored mid-run
    kick(0);
    repeat (2) step();
    for (int k = 0; k <= 20; k++) begin
      rv[0] = (k % 2) == 1;
      if (k == 5 || k == 12) begin we[0] = 1; ad[0] = 32'h0000_0FF8; wd[0] = 32'd1; end
      if (k == 8) st[0] = 1;
      if (k == 20) begin
        chk("t4.not_done_early", 64'(o_done[0]), 64'd0);
        we[0] = 1; ad[0] = TOHOST; wd[0] = 32'd1;
      end
      step();
      clr_in(0);
    end
    chk("t4.done", 64'(o_done[0]), 64'd1);
    chk("t4.retire_count", 64'(o_ret0), 64'd10);
    chk("t4.cycle_count", 64'(o_cyc0), 64'd21);
    chk("t4.pass", 64'(o_pass[0]), 64'd1);

    // Test 6: 4-bit counters saturate while the 40-cycle budget still expires
    kick(1);
    repeat (2) step();
    rv[1] = 1;
    repeat (39) step();
    chk("t6.not_done_39", 64'(o_done[1]), 64'd0);
    chk("t6.cycle_sat_39", 64'(o_cyc1), 64'd15);
    step();
    clr_in(1);
    chk("t6.done", 64'(o_done[1]), 64'd1);
    chk("t6.timeout", 64'(o_to[1]), 64'd1);
    chk("t6.cycle_count", 64'(o_cyc1), 64'd15);
    chk("t6.retire_count", 64'(o_ret1), 64'd15);

    // Test 5: async reset mid-RUN, then a normal second run
    kick(0);
    repeat (2) step();
    rv[0] = 1;
    repeat (5) step();
    #1 rst = 1;
    #1;
    chk("t5.cpu_rst_async", 64'(o_rst[0]), 64'd1);
    chk("t5.busy", 64'(o_busy[0]), 64'd0);
    chk("t5.cycle_count", 64'(o_cyc0), 64'd0);
    chk("t5.retire_count", 64'(o_ret0), 64'd0);
    clr_in(0);
    @(posedge clk);
    #3 rst = 0;
    kick(0);
    repeat (2) step();
    repeat (3) step();
    we[0] = 1; ad[0] = TOHOST; wd[0] = 32'd7;
    step();
    clr_in(0);
    chk("t5.done", 64'(o_done[0]), 64'd1);
    chk("t5.fail", 64'(o_fail[0]), 64'd1);
    chk("t5.fail_code", 64'(o_code[0]), 64'd7);
    chk("t5.cycle_count", 64'(o_cyc0), 64'd4);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
